io_phase_gate_seq: RTL and testbench

//  Sequencer for the gated 8-phase clock split/align path.
//  - Power-up order: enable the regulator domain, wait a settle time, then ungate

---
 rtl/io_phase_gate_seq_if.sv | 28 ++
 rtl/io_phase_gate_seq.sv | 165 ++++++++++++++++
 tb/tb_io_phase_gate_seq.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_phase_gate_seq_if.sv
// rtl/io_phase_gate_seq_if.sv - request/status bundle between power management and the phase gate sequencer
interface io_phase_gate_seq_if #(
  parameter int NPH      = 8,
  parameter int SETTLE_W = 8,
  parameter int STEP_W   = 4
) ();
  logic                pwr_req;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [STEP_W-1:0]   step_cnt;
  logic                err_clr;
  logic                reg_en;
  logic [NPH-1:0]      ph_en;
  logic                pwr_ack;
  logic                busy;
  logic                err;

  // Power-management side: issues requests and configuration, observes status.
  modport master (
    output pwr_req, settle_cnt, step_cnt, err_clr,
    input  reg_en, ph_en, pwr_ack, busy, err
  );

  // Sequencer side.
  modport slave (
    input  pwr_req, settle_cnt, step_cnt, err_clr,
    output reg_en, ph_en, pwr_ack, busy, err
  );
endinterface

// File: rtl/io_phase_gate_seq.sv
// rtl/io_phase_gate_seq.sv - regulator + staggered per-phase clock gate sequencer (optional sticky error: IO_PGSEQ_ERR_EN)
module io_phase_gate_seq #(
  parameter int NPH      = 8,
  parameter int SETTLE_W = 8,
  parameter int STEP_W   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  io_phase_gate_seq_if.slave      bus
);

  localparam int IDX_W = $clog2(NPH + 1);
  localparam logic [IDX_W-1:0]    NPH_IDX    = IDX_W'(NPH);
  localparam logic [IDX_W-1:0]    IDX_ONE    = IDX_W'(1);
  localparam logic [SETTLE_W-1:0] SETTLE_ONE = SETTLE_W'(1);
  localparam logic [STEP_W-1:0]   STEP_ONE   = STEP_W'(1);

  typedef enum logic [2:0] {
    S_OFF,
    S_REG_WAIT,
    S_UNGATE,
    S_ON,
    S_GATE
  } state_t;

  state_t              state_q, state_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                reg_en_q, reg_en_d;
  logic [NPH-1:0]      ph_en_q, ph_en_d;
  logic                ack_q, ack_d;
  logic                busy_q, busy_d;
  logic                err_q;

  // State register and all registered outputs; reset drops everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_OFF;
      cnt_q    <= '0;
      step_q   <= '0;
      idx_q    <= '0;
      reg_en_q <= 1'b0;
      ph_en_q  <= '0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      idx_q    <= idx_d;
      reg_en_q <= reg_en_d;
      ph_en_q  <= ph_en_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state and next-output logic; a running sequence ignores pwr_req until it lands in ON or OFF.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    step_d   = step_q;
    idx_d    = idx_q;
    reg_en_d = reg_en_q;
    ph_en_d  = ph_en_q;
    ack_d    = ack_q;
    case (state_q)
      S_OFF: begin
        if (bus.pwr_req) begin
          reg_en_d = 1'b1;
          cnt_d    = bus.settle_cnt;
          state_d  = S_REG_WAIT;
        end
      end
      S_REG_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - SETTLE_ONE;
        end else begin
          step_d  = '0;
          idx_d   = '0;
          state_d = S_UNGATE;
        end
      end
      S_UNGATE: begin
        if (step_q != '0) begin
          step_d = step_q - STEP_ONE;
        end else if (idx_q < NPH_IDX) begin
          for (int i = 0; i < NPH; i++) begin
            if (idx_q == IDX_W'(i)) ph_en_d[i] = 1'b1;
          end
          idx_d  = idx_q + IDX_ONE;
          step_d = bus.step_cnt;
        end else begin
          ack_d   = 1'b1;
          state_d = S_ON;
        end
      end
      S_ON: begin
        if (!bus.pwr_req) begin
          ack_d   = 1'b0;
          step_d  = '0;
          idx_d   = NPH_IDX;
          state_d = S_GATE;
        end
      end
      S_GATE: begin
        if (step_q != '0) begin
          step_d = step_q - STEP_ONE;
        end else if (idx_q != '0) begin
          // idx points one past the highest phase still running
          for (int i = 0; i < NPH; i++) begin
            if (idx_q == IDX_W'(i + 1)) ph_en_d[i] = 1'b0;
          end
          idx_d  = idx_q - IDX_ONE;
          step_d = bus.step_cnt;
        end else begin
          reg_en_d = 1'b0;
          state_d  = S_OFF;
        end
      end
      default: begin
        state_d = S_OFF;
      end
    endcase
    busy_d = (state_d == S_REG_WAIT) || (state_d == S_UNGATE) || (state_d == S_GATE);
  end

`ifdef IO_PGSEQ_ERR_EN
  logic seq_target;
  logic err_d;

  // A request level that disagrees with the running sequence's direction is a protocol error; set beats clear.
  always_comb begin
    seq_target = (state_q == S_REG_WAIT) || (state_q == S_UNGATE);
    err_d      = err_q;
    if (busy_q && (bus.pwr_req != seq_target)) begin
      err_d = 1'b1;
    end else if (bus.err_clr) begin
      err_d = 1'b0;
    end
  end

  // Sticky error flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`else
  logic err_clr_unused;

  assign err_clr_unused = bus.err_clr;
  assign err_q          = 1'b0;
`endif

  assign bus.reg_en  = reg_en_q;
  assign bus.ph_en   = ph_en_q;
  assign bus.pwr_ack = ack_q;
  assign bus.busy    = busy_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_io_phase_gate_seq.sv
// tb/tb_io_phase_gate_seq.sv - self-checking bench for the phase gate sequencer
module tb_io_phase_gate_seq;
  localparam int NPH      = 8;
  localparam int SETTLE_W = 8;
  localparam int STEP_W   = 4;

  localparam int M_OFF = 0;
  localparam int M_UP  = 1;
  localparam int M_ON  = 2;
  localparam int M_DN  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  io_phase_gate_seq_if #(.NPH(NPH), .SETTLE_W(SETTLE_W), .STEP_W(STEP_W)) bus ();

  io_phase_gate_seq #(.NPH(NPH), .SETTLE_W(SETTLE_W), .STEP_W(STEP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic           req;
    logic [7:0]     settle;
    logic [3:0]     step;
    logic           reg_e;
    logic [NPH-1:0] ph;
    logic           ack;
    logic           busy;
  } vec_t;

  vec_t vecs[21];

  int tests = 0;
  int fails = 0;

  // Reference model: tracks which sequence is running and since which edge, and derives outputs from elapsed time.
  int             m_mode, m_n, m_t0, m_T, m_S;
  logic           m_reg, m_ack, m_busy, m_err;
  logic [NPH-1:0] m_ph;

  logic [NPH-1:0] rph[40];
  logic           rreg[40];
  logic           rack[40];
  logic           rbusy[40];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] outs();
    return {bus.reg_en, bus.ph_en, bus.pwr_ack, bus.busy, bus.err};
  endfunction

  task automatic model_reset();
    m_mode = M_OFF;
    m_n    = 0;
    m_t0   = 0;
    m_T    = 0;
    m_S    = 0;
    m_reg  = 1'b0;
    m_ack  = 1'b0;
    m_busy = 1'b0;
    m_err  = 1'b0;
    m_ph   = '0;
  endtask

  task automatic model_edge();
    int e;
    int n_on;
`ifdef IO_PGSEQ_ERR_EN
    if ((m_mode == M_UP || m_mode == M_DN) && (bus.pwr_req != (m_mode == M_UP)))
      m_err = 1'b1;
    else if (bus.err_clr)
      m_err = 1'b0;
`endif
    m_n++;
    case (m_mode)
      M_OFF: if (bus.pwr_req) begin
        m_mode = M_UP; m_t0 = m_n; m_T = int'(bus.settle_cnt); m_S = int'(bus.step_cnt);
      end
      M_ON: if (!bus.pwr_req) begin
        m_mode = M_DN; m_t0 = m_n; m_S = int'(bus.step_cnt);
      end
      M_UP: if (m_n - m_t0 == m_T + 2 + NPH * (m_S + 1)) m_mode = M_ON;
      M_DN: if (m_n - m_t0 == 1 + NPH * (m_S + 1)) m_mode = M_OFF;
      default: m_mode = M_OFF;
    endcase
    e = m_n - m_t0;
    case (m_mode)
      M_UP: begin
        n_on = (e < m_T + 2) ? 0 : (e - m_T - 2) / (m_S + 1) + 1;
        if (n_on > NPH) n_on = NPH;
        m_ph = NPH'((1 << n_on) - 1);
        m_reg = 1'b1; m_ack = 1'b0; m_busy = 1'b1;
      end
      M_ON: begin
        m_ph = '1; m_reg = 1'b1; m_ack = 1'b1; m_busy = 1'b0;
      end
      M_DN: begin
        n_on = (e < 1) ? 0 : (e - 1) / (m_S + 1) + 1;
        if (n_on > NPH) n_on = NPH;
        m_ph = NPH'(((1 << NPH) - 1) >> n_on);
        m_reg = 1'b1; m_ack = 1'b0; m_busy = 1'b1;
      end
      default: begin
        m_ph = '0; m_reg = 1'b0; m_ack = 1'b0; m_busy = 1'b0;
      end
    endcase
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("model", 32'(outs()), 32'({m_reg, m_ph, m_ack, m_busy, m_err}));
  endtask

  task automatic record(input int n);
    for (int i = 0; i < n; i++) begin
      cycle();
      rph[i]   = bus.ph_en;
      rreg[i]  = bus.reg_en;
      rack[i]  = bus.pwr_ack;
      rbusy[i] = bus.busy;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // settle 0 / step 0 power-up then power-down, one row per edge
    vecs[0]  = '{1'b1, 8'd0, 4'd0, 1'b1, 8'h00, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 8'd0, 4'd0, 1'b1, 8'h00, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 8'd0, 4'd0, 1'b1, 8'h01, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 8'd0, 4'd0, 1'b1, 8'h03, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 8'd0, 4'd0, 1'b1, 8'h07, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 8'd0, 4'd0, 1'b1, 8'h0F, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 8'd0, 4'd0, 1'b1, 8'h1F, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 8'd0, 4'd0, 1'b1, 8'h3F, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 8'd0, 4'd0, 1'b1, 8'h7F, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 8'd0, 4'd0, 1'b1, 8'hFF, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 8'd0, 4'd0, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 8'd0, 4'd0, 1'b1, 8'hFF, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 8'd0, 4'd0, 1'b1, 8'h7F, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 8'd0, 4'd0, 1'b1, 8'h3F, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 8'd0, 4'd0, 1'b1, 8'h1F, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 8'd0, 4'd0, 1'b1, 8'h0F, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 8'd0, 4'd0, 1'b1, 8'h07, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 8'd0, 4'd0, 1'b1, 8'h03, 1'b0, 1'b1};
    vecs[18] = '{1'b0, 8'd0, 4'd0, 1'b1, 8'h01, 1'b0, 1'b1};
    vecs[19] = '{1'b0, 8'd0, 4'd0, 1'b1, 8'h00, 1'b0, 1'b1};
    vecs[20] = '{1'b0, 8'd0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0};

    bus.pwr_req    = 1'b0;
    bus.settle_cnt = '0;
    bus.step_cnt   = '0;
    bus.err_clr    = 1'b0;
    model_reset();

    repeat (3) @(negedge clk);
    chk("reset_state", 32'(outs()), 32'h0);
    rst_n = 1'b1;
    cycle();

    for (int i = 0; i < 21; i++) begin
      bus.pwr_req    = vecs[i].req;
      bus.settle_cnt = vecs[i].settle;
      bus.step_cnt   = vecs[i].step;
      cycle();
      chk($sformatf("vec%0d", i), 32'({bus.reg_en, bus.ph_en, bus.pwr_ack, bus.busy}),
          32'({vecs[i].reg_e, vecs[i].ph, vecs[i].ack, vecs[i].busy}));
    end

    // power-up with settle 2, step 0; index i is edge k+i
    bus.settle_cnt = 8'd2;
    bus.step_cnt   = 4'd0;
    bus.pwr_req    = 1'b1;
    record(15);
    chk("t1_reg_k", 32'(rreg[0]), 32'd1);
    chk("t1_ph0_k3", 32'(rph[3][0]), 32'd0);
    chk("t1_ph0_k4", 32'(rph[4][0]), 32'd1);
    chk("t1_ph7_k10", 32'(rph[10][7]), 32'd0);
    chk("t1_ph7_k11", 32'(rph[11][7]), 32'd1);
    chk("t1_ack_k11", 32'(rack[11]), 32'd0);
    chk("t1_ack_k12", 32'(rack[12]), 32'd1);
    chk("t1_busy_k12", 32'(rbusy[12]), 32'd0);

    // power-down with step 3; index i is edge j+i
    bus.step_cnt = 4'd3;
    bus.pwr_req  = 1'b0;
    record(35);
    chk("t2_ph7_j0", 32'(rph[0][7]), 32'd1);
    chk("t2_ph7_j1", 32'(rph[1][7]), 32'd0);
    chk("t2_ph0_j28", 32'(rph[28][0]), 32'd1);
    chk("t2_ph0_j29", 32'(rph[29][0]), 32'd0);
    chk("t2_reg_j32", 32'(rreg[32]), 32'd1);
    chk("t2_reg_j33", 32'(rreg[33]), 32'd0);

    // abort: drop the request part way through ungating
    bus.settle_cnt = 8'd1;
    bus.step_cnt   = 4'd1;
    bus.pwr_req    = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (bus.ph_en == 8'h07) break;
    end
    chk("t3_reach_07", 32'(bus.ph_en), 32'h07);
    bus.pwr_req = 1'b0;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (bus.pwr_ack) break;
    end
    chk("t3_ack", 32'(bus.pwr_ack), 32'd1);
    chk("t3_ph_ff", 32'(bus.ph_en), 32'hFF);
    cycle();
    chk("t3_gate_busy", 32'(bus.busy), 32'd1);
    chk("t3_gate_ack", 32'(bus.pwr_ack), 32'd0);
`ifdef IO_PGSEQ_ERR_EN
    chk("t3_err_set", 32'(bus.err), 32'd1);
    cycle();
    cycle();
    chk("t3_err_hold", 32'(bus.err), 32'd1);
    bus.err_clr = 1'b1;
    cycle();
    bus.err_clr = 1'b0;
    chk("t3_err_clr", 32'(bus.err), 32'd0);
`else
    chk("t3_err_off", 32'(bus.err), 32'd0);
`endif

    // asynchronous reset in the middle of gating
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (bus.ph_en == 8'h3F) break;
    end
    chk("t4_reach_3f", 32'(bus.ph_en), 32'h3F);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_ph_async", 32'(bus.ph_en), 32'h0);
    chk("t4_reg_async", 32'(bus.reg_en), 32'd0);
    chk("t4_ack_busy_async", 32'({bus.pwr_ack, bus.busy}), 32'd0);
    model_reset();
    @(negedge clk);
    chk("t4_held", 32'(outs()), 32'h0);
    rst_n = 1'b1;

    // random requests and configuration
    for (int c = 0; c < 10000; c++) begin
      if (m_mode == M_OFF || m_mode == M_ON) begin
        bus.settle_cnt = ($urandom_range(0, 31) == 0) ? 8'hFF : 8'($urandom_range(0, 6));
        bus.step_cnt   = ($urandom_range(0, 15) == 0) ? 4'hF : 4'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 7) == 0) bus.pwr_req = ~bus.pwr_req;
      bus.err_clr = ($urandom_range(0, 15) == 0);
      cycle();
      chk("inv_ph_needs_reg", 32'((bus.ph_en != '0) && !bus.reg_en), 32'd0);
      chk("inv_ack_needs_ff", 32'(bus.pwr_ack && (bus.ph_en != 8'hFF)), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
